seq_checker: RTL
================

// Module: seq_checker
// PURPOSE
//   Receive-side checker for the free-running increment counter stream (q <= q + 1 mod 2^W).
//   Samples in_data on in_valid and tracks the expected next value.
//   Declares lock after LOCK_CNT consecutive correct steps; flags each miss while locked.
//   Sits at the consumer end of the counter link; used for link/bench self-check.
// PARAMETERS
//   W          3  width of checked data; arithmetic is mod 2^W
//   LOCK_CNT   4  consecutive correct samples (incl. seed) needed to assert locked; >=2
//   UNLOCK_CNT 2  consecutive misses while locked/slipping before returning to HUNT; >=1
//   ERRW       8  width of error counter
// PORTS
//   clk        in   1     clock, rising edge
//   clrn       in   1     reset, asynchronous, active-low
//   in_valid   in   1     in_data valid this cycle; no backpressure, checker always accepts
//   in_data    in   W     received counter value
//   clear      in   1     synchronous clear of err_count only
//   locked     out  1     1 in LOCK and SLIP states
//   err_pulse  out  1     one-cycle pulse per mismatching sample accepted in LOCK/SLIP
//   err_count  out  ERRW  saturating count of err_pulse events
//   expected   out  W     value the next valid sample must carry
// BEHAVIOUR
//   All outputs registered; response appears the cycle after the in_valid sample (latency 1).
//   Reset (clrn=0, async): state=HUNT, run=0, miss=0, locked=0, err_pulse=0, err_count=0, expected=0.
//   in_valid=0: no state, run, miss or expected change; err_pulse=0.
//   States: HUNT, SYNC, LOCK, SLIP (state typedef from the package).
//   HUNT:  valid -> expected=data+1, run=1, go SYNC. Never flags errors.
//   SYNC:  valid & data==expected -> run++, expected=data+1; run reaches LOCK_CNT -> LOCK.
//          valid & mismatch -> reseed: expected=data+1, run=1, stay SYNC; no err_pulse.
//   LOCK:  match -> expected=data+1, stay. Mismatch -> err_pulse, miss=1,
//          expected=expected+1 (flywheel), go SLIP; if UNLOCK_CNT==1 go HUNT.
//   SLIP:  match -> miss=0, expected=data+1, LOCK. Mismatch -> err_pulse, miss++,
//          expected=expected+1; if miss reaches UNLOCK_CNT -> HUNT, run=0.
//   Wrap: 2^W-1 followed by 0 is a match; all +1 arithmetic truncated to W bits.
//   err_count: +1 per err_pulse, saturates at 2^ERRW-1 (no wrap).
//   clear and error in same cycle: clear wins, err_count=0.
//   clear does not affect state, lock or expected.
//   clrn asserted mid-stream: immediate return to reset values; relock from HUNT.
// CONFIGURATION
//   SEQ_CHK_ERRCNT_EN defined: err_count counter implemented as above.
//   Not defined: counter removed; err_count tied to 0; clear ignored; err_pulse unchanged.
// STRUCTURE
//   Package seq_chk_pkg: state enum typedef (HUNT/SYNC/LOCK/SLIP), default W/LOCK_CNT/UNLOCK_CNT.
//   One sub-module: seq_chk_sat_cnt (ERRW-bit saturating counter with inc and sync clear);
//   instanced only under SEQ_CHK_ERRCNT_EN. FSM, run/miss counters inline.
// TESTING
//   Feed 0,1,2,3 valid back-to-back -> locked=1 the cycle after 3; expected=4; err_count=0.
//   Locked, feed 5,6,7,0,1 -> wrap accepted, no err_pulse, expected=2.
//   Locked, expected=2, feed 5 then 3 -> one err_pulse, SLIP then LOCK, err_count=1.
//   Locked, feed 5,5 with UNLOCK_CNT=2 -> two err_pulses, locked=0, HUNT.
//   Force 255 errors, clear asserted with another error -> err_count 255 saturates, then 0.
//   Deassert clrn mid-stream with in_valid gaps -> all outputs 0; relock needs LOCK_CNT samples.

Source files
------------

// File: rtl/seq_chk_pkg.sv
// seq_chk_pkg: shared state type and default parameters for the increment-counter stream checker.
package seq_chk_pkg;
    typedef enum logic [1:0] {HUNT, SYNC, LOCK, SLIP} seq_state_t;
    localparam int SEQ_W          = 3;
    localparam int SEQ_LOCK_CNT   = 4;
    localparam int SEQ_UNLOCK_CNT = 2;
endpackage

// File: rtl/seq_chk_sat_cnt.sv
// seq_chk_sat_cnt: saturating event counter with synchronous clear that overrides increment.
module seq_chk_sat_cnt #(
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            clear,
    input  logic            inc,
    output logic [ERRW-1:0] count
);
    always_ff @(posedge clk or negedge clrn)
        if (!clrn)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
endmodule

// File: rtl/seq_checker.sv
// seq_checker: lock/flywheel checker for a free-running +1 counter stream.
// Error counter is built only when SEQ_CHK_ERRCNT_EN is defined; otherwise err_count reads 0.
module seq_checker
    import seq_chk_pkg::*;
#(
    parameter int W          = SEQ_W,
    parameter int LOCK_CNT   = SEQ_LOCK_CNT,
    parameter int UNLOCK_CNT = SEQ_UNLOCK_CNT,
    parameter int ERRW       = 8
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            in_valid,
    input  logic [W-1:0]    in_data,
    input  logic            clear,
    output logic            locked,
    output logic            err_pulse,
    output logic [ERRW-1:0] err_count,
    output logic [W-1:0]    expected
);
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);
    seq_state_t     state, state_n;
    logic [RW-1:0]  run, run_n;
    logic [MW-1:0]  miss, miss_n;
    logic [W-1:0]   exp_n;
    logic           err_n;
    logic           match;
    logic [W-1:0]   data_inc, exp_inc;
    assign match    = in_data == expected;
    assign data_inc = in_data + W'(1);
    assign exp_inc  = expected + W'(1);
    assign locked   = state == LOCK || state == SLIP;
    always_comb begin
        state_n = state;
        run_n   = run;
        miss_n  = miss;
        exp_n   = expected;
        err_n   = 1'b0;
        if (in_valid)
            case (state)
                HUNT: begin
                    exp_n   = data_inc;
                    run_n   = RW'(1);
                    state_n = SYNC;
                end
                SYNC: begin
                    exp_n   = data_inc;
                    run_n   = match ? run + 1'b1 : RW'(1);
                    state_n = match && run_n == RW'(LOCK_CNT) ? LOCK : SYNC;
                end
                default:
                    if (match) begin
                        exp_n   = data_inc;
                        miss_n  = '0;
                        state_n = LOCK;
                    end else begin
                        // flywheel: keep counting through the miss so a single glitch relocks
                        err_n   = 1'b1;
                        exp_n   = exp_inc;
                        miss_n  = state == LOCK ? MW'(1) : miss + 1'b1;
                        state_n = miss_n == MW'(UNLOCK_CNT) ? HUNT : SLIP;
                        if (miss_n == MW'(UNLOCK_CNT)) begin
                            run_n  = '0;
                            miss_n = '0;
                        end
                    end
            endcase
    end
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) begin
            state     <= HUNT;
            run       <= '0;
            miss      <= '0;
            expected  <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            run       <= run_n;
            miss      <= miss_n;
            expected  <= exp_n;
            err_pulse <= err_n;
        end
`ifdef SEQ_CHK_ERRCNT_EN
    seq_chk_sat_cnt #(.ERRW(ERRW)) u_err_cnt (
        .clk   (clk),
        .clrn  (clrn),
        .clear (clear),
        .inc   (err_n),
        .count (err_count)
    );
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign err_count    = '0;
`endif
endmodule
